// File: rtl/mem_stage_dm.sv
// MEM-stage data memory: word/half/byte loads and stores with an optional wait-state FSM
// that stalls upstream. Define DM_DISPLAY_EN to print a trace line for every committed store.
module mem_stage_dm #(
   parameter int DEPTH_WORDS = 4096,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] M_I,
   input  logic [31:0] M_PC,
   input  logic [31:0] M_AO,
   input  logic [31:0] M_WD,
   output logic        stall,
   output logic [31:0] O_I,
   output logic [31:0] O_PC,
   output logic [31:0] O_AO,
   output logic [31:0] O_RD
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SB  = 6'b101000;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      mem_q [DEPTH_WORDS];

   logic             is_load, is_store, is_half, is_byte, is_signed, is_mem;
   logic             done, commit;
   logic [IDX_W-1:0] idx;
   logic [1:0]       lane;
   logic [31:0]      cur_word, st_word, ld_word;

   // Extract the addressed lane (little-endian) and sign/zero extend it.
   function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] ln,
                                            input logic half, input logic byt,
                                            input logic sgn);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [31:0]        r;
      case (ln)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = ln[1] ? w[31:16] : w[15:0];
      if (byt)
         r = sgn ? 32'(b) : {24'h0, b};
      else if (half)
         r = sgn ? 32'(h) : {16'h0, h};
      else
         r = w;
      return r;
   endfunction

   // Merge store data into the current word; untouched lanes keep their value.
   function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                               input logic [1:0] ln, input logic half,
                                               input logic byt);
      logic [31:0] m;
      m = w;
      if (byt) begin
         case (ln)
            2'd0:    m[7:0]   = d[7:0];
            2'd1:    m[15:8]  = d[7:0];
            2'd2:    m[23:16] = d[7:0];
            default: m[31:24] = d[7:0];
         endcase
      end else if (half) begin
         if (ln[1]) m[31:16] = d[15:0];
         else       m[15:0]  = d[15:0];
      end else begin
         m = d;
      end
      return m;
   endfunction

   always_comb begin
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_half   = 1'b0;
      is_byte   = 1'b0;
      is_signed = 1'b0;
      case (M_I[31:26])
         OP_LW:  is_load = 1'b1;
         OP_LH:  begin is_load = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
         OP_LHU: begin is_load = 1'b1; is_half = 1'b1; end
         OP_LB:  begin is_load = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
         OP_LBU: begin is_load = 1'b1; is_byte = 1'b1; end
         OP_SW:  is_store = 1'b1;
         OP_SH:  begin is_store = 1'b1; is_half = 1'b1; end
         OP_SB:  begin is_store = 1'b1; is_byte = 1'b1; end
         default: ;
      endcase
   end

   assign is_mem   = is_load | is_store;
   assign idx      = M_AO[IDX_W+1:2];
   assign lane     = M_AO[1:0];
   assign cur_word = mem_q[idx];
   assign st_word  = store_merge(cur_word, M_WD, lane, is_half, is_byte);
   assign ld_word  = load_ext(cur_word, lane, is_half, is_byte, is_signed);

   // Completion cycle: every mem op with no wait states, else the last WAIT cycle.
   always_comb begin
      if (WAIT_CYCLES == 0) begin
         done  = is_mem;
         stall = 1'b0;
      end else begin
         done  = (state_q == S_WAIT) && (cnt_q == CNT_LAST);
         stall = !reset && (((state_q == S_IDLE) && is_mem) ||
                            ((state_q == S_WAIT) && (cnt_q != CNT_LAST)));
      end
   end

   assign commit = done && is_store;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (WAIT_CYCLES != 0) begin
         case (state_q)
            S_IDLE: begin
               if (is_mem) begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_ONE;
               end
            end
            S_WAIT: begin
               if (cnt_q == CNT_LAST) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Reset clears the whole array, which also drops any store still in its wait states.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
      end else if (commit) begin
         mem_q[idx] <= st_word;
      end
   end

   assign O_I  = stall ? 32'h0 : M_I;
   assign O_PC = M_PC;
   assign O_AO = M_AO;
   assign O_RD = (!reset && !stall && done && is_load) ? ld_word : 32'h0;

`ifdef DM_DISPLAY_EN
   always @(posedge clk) begin
      if (!reset && commit)
         $display("%d@%h: *%h <= %h", $time, M_PC, {M_AO[31:2], 2'b00}, st_word);
   end
`endif

endmodule

// File: tb/tb_mem_stage_dm.sv
// Directed bench for mem_stage_dm: one instance without wait states, one with two.
module tb_mem_stage_dm;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset0, reset2;
   logic [31:0] i0, pc0, ao0, wd0, i2, pc2, ao2, wd2;
   logic        stall0, stall2;
   logic [31:0] oi0, opc0, oao0, ord0, oi2, opc2, oao2, ord2;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [5:0] LW = 6'h23, LH = 6'h21, LHU = 6'h25, LB = 6'h20, LBU = 6'h24;
   localparam logic [5:0] SW = 6'h2b, SH = 6'h29, SB = 6'h28;
   localparam logic [31:0] ADDU = 32'h00641821;

   mem_stage_dm #(.DEPTH_WORDS(4096), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset0), .M_I(i0), .M_PC(pc0), .M_AO(ao0), .M_WD(wd0),
      .stall(stall0), .O_I(oi0), .O_PC(opc0), .O_AO(oao0), .O_RD(ord0));

   mem_stage_dm #(.DEPTH_WORDS(4096), .WAIT_CYCLES(2)) dut2 (
      .clk(clk), .reset(reset2), .M_I(i2), .M_PC(pc2), .M_AO(ao2), .M_WD(wd2),
      .stall(stall2), .O_I(oi2), .O_PC(opc2), .O_AO(oao2), .O_RD(ord2));

   function automatic logic [31:0] ins(input logic [5:0] op);
      return {op, 5'd3, 5'd4, 16'h0};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic d0(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] w);
      i0 = instr; ao0 = a; wd0 = w; pc0 = pc0 + 32'd4;
      #1;
   endtask

   task automatic d2(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] w);
      i2 = instr; ao2 = a; wd2 = w; pc2 = pc2 + 32'd4;
      #1;
   endtask

   initial begin
      reset0 = 1'b1; reset2 = 1'b1;
      pc0 = 32'h0040_0000; pc2 = 32'h0080_0000;
      i0 = ins(SW); ao0 = 32'h10; wd0 = 32'hDEADBEEF;
      i2 = ins(LW); ao2 = 32'h10; wd2 = 32'h0;
      #2;
      chk("rst0_stall", {31'h0, stall0}, 32'h0);
      chk("rst0_oi", oi0, ins(SW));
      chk("rst0_ord", ord0, 32'h0);
      chk("rst2_stall", {31'h0, stall2}, 32'h0);
      chk("rst2_oi", oi2, ins(LW));
      chk("rst2_opc", opc2, 32'h0080_0000);
      tick();
      tick();
      reset0 = 1'b0; reset2 = 1'b0;
      i2 = ADDU;

      // ---- no-wait-state instance ----
      d0(ins(SW), 32'h10, 32'h12345678);
      chk("n0_sw_stall", {31'h0, stall0}, 32'h0);
      chk("n0_sw_oi", oi0, ins(SW));
      chk("n0_sw_ord", ord0, 32'h0);
      tick();
      d0(ins(LW), 32'h10, 32'h0);
      chk("n0_lw", ord0, 32'h12345678);
      chk("n0_lw_stall", {31'h0, stall0}, 32'h0);
      tick();
      d0(ins(SB), 32'h13, 32'hFFFFFF80);
      tick();
      d0(ins(LB), 32'h13, 32'h0);
      chk("n0_lb", ord0, 32'hFFFFFF80);
      tick();
      d0(ins(LBU), 32'h13, 32'h0);
      chk("n0_lbu", ord0, 32'h00000080);
      tick();
      d0(ins(LW), 32'h10, 32'h0);
      chk("n0_lw_merge", ord0, 32'h80345678);
      tick();
      d0(ins(LBU), 32'h11, 32'h0);
      chk("n0_lbu1", ord0, 32'h00000056);
      tick();
      d0(ins(SH), 32'h22, 32'h55558001);
      tick();
      d0(ins(LH), 32'h22, 32'h0);
      chk("n0_lh", ord0, 32'hFFFF8001);
      tick();
      d0(ins(LHU), 32'h22, 32'h0);
      chk("n0_lhu_hi", ord0, 32'h00008001);
      tick();
      d0(ins(LHU), 32'h20, 32'h0);
      chk("n0_lhu_lo", ord0, 32'h0);
      tick();
      d0(ins(LW), 32'h20, 32'h0);
      chk("n0_lw_half", ord0, 32'h80010000);
      tick();
      d0(ADDU, 32'h10, 32'hCAFEF00D);
      chk("n0_addu_stall", {31'h0, stall0}, 32'h0);
      chk("n0_addu_oi", oi0, ADDU);
      chk("n0_addu_ord", ord0, 32'h0);
      chk("n0_addu_oao", oao0, 32'h10);
      chk("n0_addu_opc", opc0, pc0);
      tick();
      d0(ins(LW), 32'h13, 32'h0);
      chk("n0_lw_unaligned", ord0, 32'h80345678);
      tick();
      d0(ins(LW), 32'h4010, 32'h0);
      chk("n0_lw_wrap", ord0, 32'h80345678);
      tick();

      // ---- two-wait-state instance ----
      d2(ADDU, 32'h10, 32'hCAFEF00D);
      chk("n2_addu_stall", {31'h0, stall2}, 32'h0);
      chk("n2_addu_oi", oi2, ADDU);
      chk("n2_addu_ord", ord2, 32'h0);
      tick();
      d2(ins(SW), 32'h10, 32'h12345678);
      chk("n2_sw_c1_stall", {31'h0, stall2}, 32'h1);
      chk("n2_sw_c1_oi", oi2, 32'h0);
      tick();
      chk("n2_sw_c2_stall", {31'h0, stall2}, 32'h1);
      chk("n2_sw_c2_oi", oi2, 32'h0);
      tick();
      chk("n2_sw_c3_stall", {31'h0, stall2}, 32'h0);
      chk("n2_sw_c3_oi", oi2, ins(SW));
      tick();
      d2(ins(LW), 32'h10, 32'h0);
      chk("n2_lw_c1_stall", {31'h0, stall2}, 32'h1);
      chk("n2_lw_c1_oi", oi2, 32'h0);
      chk("n2_lw_c1_ord", ord2, 32'h0);
      tick();
      chk("n2_lw_c2_stall", {31'h0, stall2}, 32'h1);
      chk("n2_lw_c2_oi", oi2, 32'h0);
      tick();
      chk("n2_lw_c3_stall", {31'h0, stall2}, 32'h0);
      chk("n2_lw_c3_oi", oi2, ins(LW));
      chk("n2_lw_c3_ord", ord2, 32'h12345678);
      tick();
      d2(ins(SW), 32'h40, 32'hAABBCCDD);
      chk("n2_sw40_c1_stall", {31'h0, stall2}, 32'h1);
      tick();
      reset2 = 1'b1;
      #1;
      chk("n2_rst_stall", {31'h0, stall2}, 32'h0);
      chk("n2_rst_oi", oi2, ins(SW));
      chk("n2_rst_ord", ord2, 32'h0);
      tick();
      reset2 = 1'b0;
      d2(ins(LW), 32'h40, 32'h0);
      chk("n2_post_c1_stall", {31'h0, stall2}, 32'h1);
      tick();
      chk("n2_post_c2_stall", {31'h0, stall2}, 32'h1);
      tick();
      chk("n2_post_c3_stall", {31'h0, stall2}, 32'h0);
      chk("n2_post_lw40", ord2, 32'h0);
      tick();
      d2(ins(LW), 32'h10, 32'h0);
      tick();
      tick();
      chk("n2_post_lw10", ord2, 32'h0);
      tick();
      d2(ADDU, 32'h0, 32'h0);
      chk("n2_idle_stall", {31'h0, stall2}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
